complex_dot4_mac: RTL

- Sequential complex dot-product engine that sits directly downstream of the matrix-A row multiplexer and the matrix-B column multiplexer in the 4x4 complex matrix multiplier.
- Accepts one row of A and one column of B, each as 4 signed complex elements, with a valid/ready handshake.
- Accumulates the 4 complex products serially, one per clock, and presents one complex element of C with its row/column tag.
- The top-level sequencer steps the A/B selects and issues 16 transactions per matrix product.

---
 rtl/complex_dot4_mac.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/complex_dot4_mac.sv
//------------------------------------------------------------------------------
// Module      : complex_dot4_mac
// Description : Serial 4-element signed complex dot-product MAC with
//               valid/ready handshakes on the operand and result sides.
//               Optional macro DOT4_PIPE_MUL_EN adds a product register stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module complex_dot4_mac #(
   parameter  int Width    = 8,
   localparam int AccWidth = 2*Width+3
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       IN_VALID,
   output logic                       IN_READY,
   input  logic signed [Width-1:0]    InA1Real,
   input  logic signed [Width-1:0]    InA2Real,
   input  logic signed [Width-1:0]    InA3Real,
   input  logic signed [Width-1:0]    InA4Real,
   input  logic signed [Width-1:0]    InA1Imag,
   input  logic signed [Width-1:0]    InA2Imag,
   input  logic signed [Width-1:0]    InA3Imag,
   input  logic signed [Width-1:0]    InA4Imag,
   input  logic signed [Width-1:0]    InB1Real,
   input  logic signed [Width-1:0]    InB2Real,
   input  logic signed [Width-1:0]    InB3Real,
   input  logic signed [Width-1:0]    InB4Real,
   input  logic signed [Width-1:0]    InB1Imag,
   input  logic signed [Width-1:0]    InB2Imag,
   input  logic signed [Width-1:0]    InB3Imag,
   input  logic signed [Width-1:0]    InB4Imag,
   input  logic [1:0]                 ROW_IN,
   input  logic [1:0]                 COL_IN,
   output logic                       OUT_VALID,
   input  logic                       OUT_READY,
   output logic signed [AccWidth-1:0] OutReal,
   output logic signed [AccWidth-1:0] OutImag,
   output logic [1:0]                 ROW_OUT,
   output logic [1:0]                 COL_OUT,
   output logic                       BUSY
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic signed [2*Width-1:0] f_sx2(input logic signed [Width-1:0] v);
      return {{Width{v[Width-1]}}, v};
   endfunction

   function automatic logic signed [AccWidth-1:0] f_ext(input logic signed [2*Width-1:0] v);
      return {{(AccWidth-2*Width){v[2*Width-1]}}, v};
   endfunction

   state_t                     r_state;
   logic [2:0]                 r_k;
   logic signed [Width-1:0]    r_ar [4];
   logic signed [Width-1:0]    r_ai [4];
   logic signed [Width-1:0]    r_br [4];
   logic signed [Width-1:0]    r_bi [4];
   logic [1:0]                 r_row;
   logic [1:0]                 r_col;
   logic signed [AccWidth-1:0] r_acc_re;
   logic signed [AccWidth-1:0] r_acc_im;
   logic                       r_in_ready;
   logic                       r_out_valid;
   logic                       r_busy;
   logic signed [AccWidth-1:0] r_out_re;
   logic signed [AccWidth-1:0] r_out_im;
   logic [1:0]                 r_row_out;
   logic [1:0]                 r_col_out;

   logic signed [Width-1:0]    w_in_ar [4];
   logic signed [Width-1:0]    w_in_ai [4];
   logic signed [Width-1:0]    w_in_br [4];
   logic signed [Width-1:0]    w_in_bi [4];
   logic signed [Width-1:0]    w_ar, w_ai, w_br, w_bi;
   logic signed [2*Width-1:0]  w_prr, w_pii, w_pri, w_pir;
   logic signed [AccWidth-1:0] w_add_re, w_add_im;

   assign w_in_ar = '{InA1Real, InA2Real, InA3Real, InA4Real};
   assign w_in_ai = '{InA1Imag, InA2Imag, InA3Imag, InA4Imag};
   assign w_in_br = '{InB1Real, InB2Real, InB3Real, InB4Real};
   assign w_in_bi = '{InB1Imag, InB2Imag, InB3Imag, InB4Imag};

   // Operands are pre-extended so the 2*Width product keeps full precision.
   assign w_ar  = r_ar[r_k[1:0]];
   assign w_ai  = r_ai[r_k[1:0]];
   assign w_br  = r_br[r_k[1:0]];
   assign w_bi  = r_bi[r_k[1:0]];
   assign w_prr = f_sx2(w_ar) * f_sx2(w_br);
   assign w_pii = f_sx2(w_ai) * f_sx2(w_bi);
   assign w_pri = f_sx2(w_ar) * f_sx2(w_bi);
   assign w_pir = f_sx2(w_ai) * f_sx2(w_br);

`ifdef DOT4_PIPE_MUL_EN
   logic signed [2*Width-1:0] r_prr, r_pii, r_pri, r_pir;

   assign w_add_re = f_ext(r_prr) - f_ext(r_pii);
   assign w_add_im = f_ext(r_pri) + f_ext(r_pir);
`else
   assign w_add_re = f_ext(w_prr) - f_ext(w_pii);
   assign w_add_im = f_ext(w_pri) + f_ext(w_pir);
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= ST_IDLE;
         r_k         <= 3'd0;
         r_row       <= 2'd0;
         r_col       <= 2'd0;
         r_acc_re    <= '0;
         r_acc_im    <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_out_re    <= '0;
         r_out_im    <= '0;
         r_row_out   <= 2'd0;
         r_col_out   <= 2'd0;
         for (int i = 0; i < 4; i++) begin
            r_ar[i] <= '0;
            r_ai[i] <= '0;
            r_br[i] <= '0;
            r_bi[i] <= '0;
         end
`ifdef DOT4_PIPE_MUL_EN
         r_prr <= '0;
         r_pii <= '0;
         r_pri <= '0;
         r_pir <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (IN_VALID) begin
                  r_ar       <= w_in_ar;
                  r_ai       <= w_in_ai;
                  r_br       <= w_in_br;
                  r_bi       <= w_in_bi;
                  r_row      <= ROW_IN;
                  r_col      <= COL_IN;
                  r_acc_re   <= '0;
                  r_acc_im   <= '0;
                  r_k        <= 3'd0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= ST_MAC;
               end
            end
            ST_MAC: begin
               r_k <= r_k + 3'd1;
`ifdef DOT4_PIPE_MUL_EN
               // Slot k loads product k while accumulating product k-1.
               if (r_k != 3'd4) begin
                  r_prr <= w_prr;
                  r_pii <= w_pii;
                  r_pri <= w_pri;
                  r_pir <= w_pir;
               end
               if (r_k != 3'd0) begin
                  r_acc_re <= r_acc_re + w_add_re;
                  r_acc_im <= r_acc_im + w_add_im;
               end
               if (r_k == 3'd4) begin
`else
               r_acc_re <= r_acc_re + w_add_re;
               r_acc_im <= r_acc_im + w_add_im;
               if (r_k == 3'd3) begin
`endif
                  r_out_re    <= r_acc_re + w_add_re;
                  r_out_im    <= r_acc_im + w_add_im;
                  r_row_out   <= r_row;
                  r_col_out   <= r_col;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (OUT_READY) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign IN_READY  = r_in_ready;
   assign OUT_VALID = r_out_valid;
   assign BUSY      = r_busy;
   assign OutReal   = r_out_re;
   assign OutImag   = r_out_im;
   assign ROW_OUT   = r_row_out;
   assign COL_OUT   = r_col_out;

endmodule

`default_nettype wire
